// File: rtl/exc_commit_pkg.sv
// rtl/exc_commit_pkg.sv - shared ExcCodes, exception flag bit indices and FSM state type for exc_commit
package exc_commit_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_TR   = 5'd13;

   // slot_exc layout, MSB first, which is also descending priority
   localparam int EXF_ADEL_IF = 7;
   localparam int EXF_RI      = 6;
   localparam int EXF_OV      = 5;
   localparam int EXF_TRAP    = 4;
   localparam int EXF_SYS     = 3;
   localparam int EXF_BRK     = 2;
   localparam int EXF_ADEL_LD = 1;
   localparam int EXF_ADES    = 0;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_REDIR = 1'b1
   } state_t;

endpackage

// File: rtl/exc_commit_if.sv
// rtl/exc_commit_if.sv - commit-stage exception bundle: slot flags in, CP0 strobes and fetch redirect out
interface exc_commit_if #(
   parameter int NSLOT = 2
);
   logic [NSLOT-1:0]        slot_valid;
   logic [NSLOT-1:0][31:0]  slot_pc;
   logic [NSLOT-1:0]        slot_bd;
   logic [NSLOT-1:0][7:0]   slot_exc;
   logic [NSLOT-1:0][31:0]  slot_badva;
   logic [NSLOT-1:0]        slot_eret;
   logic                    int_pending;
   logic [31:0]             cp0_epc;
   logic                    stall_in;
   logic                    flush;
   logic                    cp0_we;
   logic [31:0]             cp0_epc_wd;
   logic [4:0]              cp0_exccode;
   logic                    cp0_bd;
   logic                    cp0_badva_we;
   logic [31:0]             cp0_badva_wd;
   logic                    cp0_eret;
   logic                    redir_valid;
   logic [31:0]             redir_pc;
   logic                    redir_ready;
   logic                    busy;

   // master: pipeline/CP0/fetch side; slave: the commit exception unit
   modport master (
      output slot_valid, slot_pc, slot_bd, slot_exc, slot_badva, slot_eret,
      output int_pending, cp0_epc, stall_in, redir_ready,
      input  flush, cp0_we, cp0_epc_wd, cp0_exccode, cp0_bd,
      input  cp0_badva_we, cp0_badva_wd, cp0_eret, redir_valid, redir_pc, busy
   );

   modport slave (
      input  slot_valid, slot_pc, slot_bd, slot_exc, slot_badva, slot_eret,
      input  int_pending, cp0_epc, stall_in, redir_ready,
      output flush, cp0_we, cp0_epc_wd, cp0_exccode, cp0_bd,
      output cp0_badva_we, cp0_badva_wd, cp0_eret, redir_valid, redir_pc, busy
   );

endinterface

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - per-slot exception cause priority encoder (int > adel_if > ri > ov > trap > sys > brk > adel_ld > ades)
module exc_prio_enc
   import exc_commit_pkg::*;
(
   input  logic [7:0] flags,
   input  logic       int_req,
   output logic       hit,
   output logic [4:0] exccode,
   output logic       is_addr_err
);

   always_comb begin
      hit         = int_req | (|flags);
      exccode     = EXC_INT;
      is_addr_err = 1'b0;
      if (int_req) begin
         exccode = EXC_INT;
      end else if (flags[EXF_ADEL_IF]) begin
         exccode     = EXC_ADEL;
         is_addr_err = 1'b1;
      end else if (flags[EXF_RI]) begin
         exccode = EXC_RI;
      end else if (flags[EXF_OV]) begin
         exccode = EXC_OV;
      end else if (flags[EXF_TRAP]) begin
         exccode = EXC_TR;
      end else if (flags[EXF_SYS]) begin
         exccode = EXC_SYS;
      end else if (flags[EXF_BRK]) begin
         exccode = EXC_BP;
      end else if (flags[EXF_ADEL_LD]) begin
         exccode     = EXC_ADEL;
         is_addr_err = 1'b1;
      end else if (flags[EXF_ADES]) begin
         exccode     = EXC_ADES;
         is_addr_err = 1'b1;
      end
   end

endmodule

// File: rtl/exc_commit.sv
// rtl/exc_commit.sv - commit-stage exception/ERET resolution, CP0 strobes and fetch redirect
// Optional exc_count/eret_count outputs under EXC_COMMIT_STATS_EN.
module exc_commit
   import exc_commit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int          NSLOT      = 2
) (
   input  logic        clk,
   input  logic        rst,
   exc_commit_if.slave bus
`ifdef EXC_COMMIT_STATS_EN
   ,
   output logic [31:0] exc_count,
   output logic [31:0] eret_count
`endif
);

   state_t state, state_n;

   logic [NSLOT-1:0] hit;
   logic [NSLOT-1:0] addr_err;
   logic [4:0]       code [NSLOT];
   logic [NSLOT-1:0] eret_v;

   logic        sel_hit, sel_bd, sel_aerr, sel_fetch, any_ev;
   logic [31:0] sel_pc, sel_badva;
   logic [4:0]  sel_code;
   logic        take_exc, take_eret;

   logic        flush_q, we_q, bd_q, badva_we_q, eret_q;
   logic [31:0] epc_wd_q, badva_wd_q, redir_pc_q;
   logic [4:0]  exccode_q;

   assign eret_v = bus.slot_valid & bus.slot_eret;

   for (genvar i = 0; i < NSLOT; i++) begin : g_enc
      exc_prio_enc u_enc (
         .flags       (bus.slot_valid[i] ? bus.slot_exc[i] : 8'h00),
         .int_req     ((i == 0) ? (bus.slot_valid[0] & bus.int_pending) : 1'b0),
         .hit         (hit[i]),
         .exccode     (code[i]),
         .is_addr_err (addr_err[i])
      );
   end

   // Walk youngest to oldest so the oldest slot with an event wins.
   always_comb begin
      sel_hit   = 1'b0;
      sel_bd    = 1'b0;
      sel_aerr  = 1'b0;
      sel_fetch = 1'b0;
      sel_pc    = '0;
      sel_badva = '0;
      sel_code  = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (hit[i] || eret_v[i]) begin
            sel_hit   = hit[i];
            sel_bd    = bus.slot_bd[i];
            sel_aerr  = addr_err[i];
            sel_fetch = bus.slot_exc[i][EXF_ADEL_IF];
            sel_pc    = bus.slot_pc[i];
            sel_badva = bus.slot_badva[i];
            sel_code  = code[i];
         end
      end
      any_ev = |(hit | eret_v);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      take_exc  = 1'b0;
      take_eret = 1'b0;
      case (state)
         S_IDLE: begin
            if (!bus.stall_in && any_ev) begin
               state_n   = S_REDIR;
               take_exc  = sel_hit;
               take_eret = !sel_hit;
            end
         end
         S_REDIR: begin
            if (bus.redir_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_q    <= 1'b0;
         we_q       <= 1'b0;
         eret_q     <= 1'b0;
         badva_we_q <= 1'b0;
         bd_q       <= 1'b0;
         exccode_q  <= '0;
         epc_wd_q   <= '0;
         badva_wd_q <= '0;
         redir_pc_q <= '0;
      end else begin
         flush_q    <= take_exc | take_eret;
         we_q       <= take_exc;
         eret_q     <= take_eret;
         badva_we_q <= take_exc & sel_aerr;
         if (take_exc) begin
            epc_wd_q   <= sel_bd ? (sel_pc - 32'd4) : sel_pc;
            bd_q       <= sel_bd;
            exccode_q  <= sel_code;
            redir_pc_q <= EXC_VECTOR;
            if (sel_aerr) badva_wd_q <= sel_fetch ? sel_pc : sel_badva;
         end
         if (take_eret) redir_pc_q <= bus.cp0_epc;
      end
   end

`ifdef EXC_COMMIT_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_count  <= '0;
         eret_count <= '0;
      end else begin
         if (take_exc)  exc_count  <= exc_count + 32'd1;
         if (take_eret) eret_count <= eret_count + 32'd1;
      end
   end
`endif

   assign bus.flush        = flush_q;
   assign bus.cp0_we       = we_q;
   assign bus.cp0_epc_wd   = epc_wd_q;
   assign bus.cp0_exccode  = exccode_q;
   assign bus.cp0_bd       = bd_q;
   assign bus.cp0_badva_we = badva_we_q;
   assign bus.cp0_badva_wd = badva_wd_q;
   assign bus.cp0_eret     = eret_q;
   assign bus.redir_valid  = (state == S_REDIR);
   assign bus.redir_pc     = redir_pc_q;
   assign bus.busy         = (state == S_REDIR);

endmodule

// File: tb/tb_exc_commit.sv
// tb/tb_exc_commit.sv - directed self-checking bench for exc_commit
module tb_exc_commit;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   exc_commit_if #(.NSLOT(2)) bus ();

`ifdef EXC_COMMIT_STATS_EN
   logic [31:0] exc_count, eret_count;
   exc_commit #(.EXC_VECTOR(32'hBFC0_0380), .NSLOT(2)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .exc_count(exc_count), .eret_count(eret_count)
   );
`else
   exc_commit #(.EXC_VECTOR(32'hBFC0_0380), .NSLOT(2)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );
`endif

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.slot_valid  = '0;
      bus.slot_pc     = '0;
      bus.slot_bd     = '0;
      bus.slot_exc    = '0;
      bus.slot_badva  = '0;
      bus.slot_eret   = '0;
      bus.int_pending = 1'b0;
      bus.stall_in    = 1'b0;
   endtask

   task automatic trap_slot0(input logic [31:0] pc);
      bus.slot_valid[0] = 1'b1;
      bus.slot_pc[0]    = pc;
      bus.slot_exc[0]   = 8'h10;
   endtask

   task automatic finish_redir();
      bus.redir_ready = 1'b1;
      step();
      chk("redir_done_valid", {31'd0, bus.redir_valid}, 32'd0);
      chk("redir_done_busy", {31'd0, bus.busy}, 32'd0);
      bus.redir_ready = 1'b0;
   endtask

   initial begin
      clear_inputs();
      bus.cp0_epc     = '0;
      bus.redir_ready = 1'b0;
      rst = 1'b1;
      step();
      step();
      chk("rst_flush", {31'd0, bus.flush}, 32'd0);
      chk("rst_we", {31'd0, bus.cp0_we}, 32'd0);
      chk("rst_redir_valid", {31'd0, bus.redir_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_redir_pc", bus.redir_pc, 32'd0);
      rst = 1'b0;
      step();

      // trap in slot 0
      trap_slot0(32'h8000_1000);
      step();
      clear_inputs();
      chk("trap_flush", {31'd0, bus.flush}, 32'd1);
      chk("trap_we", {31'd0, bus.cp0_we}, 32'd1);
      chk("trap_code", {27'd0, bus.cp0_exccode}, 32'd13);
      chk("trap_epc", bus.cp0_epc_wd, 32'h8000_1000);
      chk("trap_bd", {31'd0, bus.cp0_bd}, 32'd0);
      chk("trap_badva_we", {31'd0, bus.cp0_badva_we}, 32'd0);
      chk("trap_eret", {31'd0, bus.cp0_eret}, 32'd0);
      chk("trap_rvalid", {31'd0, bus.redir_valid}, 32'd1);
      chk("trap_rpc", bus.redir_pc, 32'hBFC0_0380);
      chk("trap_busy", {31'd0, bus.busy}, 32'd1);
      step();
      chk("trap_flush_pulse", {31'd0, bus.flush}, 32'd0);
      chk("trap_we_pulse", {31'd0, bus.cp0_we}, 32'd0);
      chk("trap_rvalid_hold", {31'd0, bus.redir_valid}, 32'd1);
      chk("trap_rpc_hold", bus.redir_pc, 32'hBFC0_0380);
      finish_redir();

      // slot 1 ades in a delay slot, slot 0 clean
      bus.slot_valid    = 2'b11;
      bus.slot_pc[0]    = 32'h8000_2000;
      bus.slot_pc[1]    = 32'h8000_2004;
      bus.slot_bd[1]    = 1'b1;
      bus.slot_exc[1]   = 8'h01;
      bus.slot_badva[1] = 32'h0000_1003;
      step();
      clear_inputs();
      chk("ades_epc", bus.cp0_epc_wd, 32'h8000_2000);
      chk("ades_bd", {31'd0, bus.cp0_bd}, 32'd1);
      chk("ades_code", {27'd0, bus.cp0_exccode}, 32'd5);
      chk("ades_badva_we", {31'd0, bus.cp0_badva_we}, 32'd1);
      chk("ades_badva_wd", bus.cp0_badva_wd, 32'h0000_1003);
      finish_redir();

      // priority: ov+trap+sys with and without interrupt
      bus.slot_valid[0] = 1'b1;
      bus.slot_pc[0]    = 32'h8000_3000;
      bus.slot_exc[0]   = 8'h38;
      bus.int_pending   = 1'b1;
      step();
      clear_inputs();
      chk("prio_int_code", {27'd0, bus.cp0_exccode}, 32'd0);
      finish_redir();
      bus.slot_valid[0] = 1'b1;
      bus.slot_pc[0]    = 32'h8000_3000;
      bus.slot_exc[0]   = 8'h38;
      step();
      clear_inputs();
      chk("prio_ov_code", {27'd0, bus.cp0_exccode}, 32'd12);
      finish_redir();

      // ERET with ready already high: one-cycle handshake
      bus.cp0_epc       = 32'h8000_0400;
      bus.slot_valid[0] = 1'b1;
      bus.slot_eret[0]  = 1'b1;
      bus.redir_ready   = 1'b1;
      step();
      clear_inputs();
      chk("eret_flush", {31'd0, bus.flush}, 32'd1);
      chk("eret_eret", {31'd0, bus.cp0_eret}, 32'd1);
      chk("eret_we", {31'd0, bus.cp0_we}, 32'd0);
      chk("eret_rpc", bus.redir_pc, 32'h8000_0400);
      chk("eret_rvalid", {31'd0, bus.redir_valid}, 32'd1);
      step();
      chk("eret_1cyc_rvalid", {31'd0, bus.redir_valid}, 32'd0);
      bus.redir_ready = 1'b0;

      // older syscall masks younger eret
      bus.slot_valid   = 2'b11;
      bus.slot_exc[0]  = 8'h08;
      bus.slot_eret[1] = 1'b1;
      step();
      clear_inputs();
      chk("mask_code", {27'd0, bus.cp0_exccode}, 32'd8);
      chk("mask_eret", {31'd0, bus.cp0_eret}, 32'd0);
      chk("mask_we", {31'd0, bus.cp0_we}, 32'd1);
      finish_redir();

      // ready held low, new event during REDIR ignored
      trap_slot0(32'h8000_5000);
      step();
      clear_inputs();
      bus.slot_valid    = 2'b11;
      bus.slot_exc[1]   = 8'h02;
      bus.slot_badva[1] = 32'h0000_0bad;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("hs_rvalid", {31'd0, bus.redir_valid}, 32'd1);
         chk("hs_rpc", bus.redir_pc, 32'hBFC0_0380);
         chk("hs_busy", {31'd0, bus.busy}, 32'd1);
         chk("hs_flush", {31'd0, bus.flush}, 32'd0);
         chk("hs_code", {27'd0, bus.cp0_exccode}, 32'd13);
      end
      clear_inputs();
      finish_redir();

      // reset while in REDIR
      trap_slot0(32'h8000_6000);
      step();
      clear_inputs();
      chk("rr_rvalid_pre", {31'd0, bus.redir_valid}, 32'd1);
      rst = 1'b1;
      step();
      chk("rr_rvalid", {31'd0, bus.redir_valid}, 32'd0);
      chk("rr_busy", {31'd0, bus.busy}, 32'd0);
      chk("rr_flush", {31'd0, bus.flush}, 32'd0);
      chk("rr_we", {31'd0, bus.cp0_we}, 32'd0);
      chk("rr_code", {27'd0, bus.cp0_exccode}, 32'd0);
      chk("rr_rpc", bus.redir_pc, 32'd0);
      rst = 1'b0;
      step();

      // stall holds off evaluation
      trap_slot0(32'h8000_7000);
      bus.stall_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_flush", {31'd0, bus.flush}, 32'd0);
         chk("stall_busy", {31'd0, bus.busy}, 32'd0);
      end
      bus.stall_in = 1'b0;
      step();
      clear_inputs();
      chk("unstall_flush", {31'd0, bus.flush}, 32'd1);
      chk("unstall_epc", bus.cp0_epc_wd, 32'h8000_7000);
      finish_redir();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
